// File: rtl/fifo_rd_stream_adapter_pkg.sv
// Shared constants and helpers for the async_fifo read-side stream adapter.
// BUF_DEPTH is the prefetch depth (RAM read latency + 1 entry). RD_LATENCY is
// the RAM read latency shared with dualport_ram_async.
package fifo_rd_stream_adapter_pkg;

  localparam int BUF_DEPTH  = 2;
  localparam int CNT_W      = 2;
  localparam int RD_LATENCY = 1;

  typedef logic [CNT_W-1:0] cnt_t;

  // Occupancy update for one cycle: one optional push and one optional pop.
  function automatic cnt_t cnt_next(input cnt_t cnt, input logic inc, input logic dec);
    return cnt + cnt_t'(inc) - cnt_t'(dec);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_adapter_if.sv
// Bundle of the FIFO read port and the downstream valid/ready stream.
// master = the adapter, slave = the FIFO plus the downstream consumer.
interface fifo_rd_stream_adapter_if
  import fifo_rd_stream_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = 4
);

  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  cnt_t                  buf_cnt;

  modport master (
    input  fifo_empty, fifo_rd_data, m_ready,
    output fifo_rd_en, m_valid, m_data, buf_cnt
  );

  modport slave (
    output fifo_empty, fifo_rd_data, m_ready,
    input  fifo_rd_en, m_valid, m_data, buf_cnt
  );

endinterface

// File: rtl/fifo_rd_stream_adapter_stream_buf2.sv
// Two-entry register FIFO holding words returned by the async_fifo RAM.
// Head entry is presented combinationally; clr empties it synchronously.
// Data storage is not reset: only the pointers and count carry meaning.
module stream_buf2
  import fifo_rd_stream_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data,
  output cnt_t                  o_cnt
);

  logic [DATA_WIDTH-1:0] r_mem [BUF_DEPTH];
  logic                  r_hp;
  logic                  r_tp;
  cnt_t                  r_cnt;

  // Pointers wrap naturally at 1 bit; count tracks push minus pop.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_hp  <= 1'b0;
      r_tp  <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (push) r_tp <= r_tp + 1'b1;
      if (pop)  r_hp <= r_hp + 1'b1;
      r_cnt <= cnt_next(r_cnt, push, pop);
    end
  end

  // Word storage written at the tail on each accepted push.
  always_ff @(posedge clk) begin
    if (push) r_mem[r_tp] <= i_data;
  end

  assign o_data = r_mem[r_hp];
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// Read-side consumer of async_fifo. Issues rd_en whenever the prefetch buffer
// can absorb the word that returns one cycle later, giving a bubble-free
// valid/ready stream. m_valid/m_data come straight from buffer registers, so
// m_ready only reaches fifo_rd_en combinationally, never the stream outputs.
// Reset and the FIFO must be released together: a word in flight at reset is
// dropped even though the FIFO read pointer has already advanced.
module fifo_rd_stream_adapter
  import fifo_rd_stream_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int BUF_DEPTH  = 2   // only 2 is supported (latency 1 + 1)
) (
  input logic                       rd_clk,
  input logic                       rd_rst,
  input logic                       flush,
  fifo_rd_stream_adapter_if.master  bus
);

  logic                  r_ifl_p1;
  logic                  w_valid;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_rd_en;
  logic [CNT_W:0]        w_occ;
  cnt_t                  w_cnt;
  logic [DATA_WIDTH-1:0] w_head;

  assign w_valid = (w_cnt != '0);
  assign w_pop   = w_valid & bus.m_ready;
  assign w_push  = r_ifl_p1 & ~flush;

  // Entries held or owed after this cycle's pop; issue only if one slot stays free.
  assign w_occ   = {1'b0, w_cnt} + {{CNT_W{1'b0}}, r_ifl_p1} - {{CNT_W{1'b0}}, w_pop};
  assign w_rd_en = ~rd_rst & ~flush & ~bus.fifo_empty
                 & (w_occ < (CNT_W+1)'(BUF_DEPTH));

  // Stage p1: a read issued last cycle has its data on fifo_rd_data now.
  always_ff @(posedge rd_clk) begin
    if (rd_rst || flush) r_ifl_p1 <= 1'b0;
    else                 r_ifl_p1 <= w_rd_en;
  end

  stream_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk    (rd_clk),
    .rst    (rd_rst),
    .clr    (flush),
    .push   (w_push),
    .pop    (w_pop & ~flush),
    .i_data (bus.fifo_rd_data),
    .o_data (w_head),
    .o_cnt  (w_cnt)
  );

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.m_valid    = w_valid;
  assign bus.m_data     = w_head;
  assign bus.buf_cnt    = w_cnt;

endmodule
